// File: rtl/inst_prefetch_buffer.sv
// DEPTH-entry instruction prefetch FIFO between fetch and decode.
// The head entry is presented show-ahead and sliced into MIPS R/I/J fields.
module inst_prefetch_buffer #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic [5:0]                 opcode,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [5:0]                 funct,
    output logic [15:0]                imm,
    output logic [25:0]                target,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Handshakes: a transfer happens on an edge where valid && ready are both
    // high; flush overrides both sides and the presented word is dropped.
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed while count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= in_inst;
            pc_mem[wr_ptr_q]   <= in_pc;
        end
    end

    // An empty buffer presents all zeros, which decodes as sll $0,$0,0.
    assign out_inst = out_valid ? inst_mem[rd_ptr_q] : '0;
    assign out_pc   = out_valid ? pc_mem[rd_ptr_q]   : '0;

    assign opcode = out_inst[31:26];
    assign rs     = out_inst[25:21];
    assign rt     = out_inst[20:16];
    assign rd     = out_inst[15:11];
    assign shamt  = out_inst[10:6];
    assign funct  = out_inst[5:0];
    assign imm    = out_inst[15:0];
    assign target = out_inst[25:0];

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed self-checking bench for inst_prefetch_buffer (DEPTH=4).
module tb_inst_prefetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] head;

    inst_prefetch_buffer #(.DATA_W(32), .PC_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .count(count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance one edge and settle 1ns after it, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst: got %h exp 0", out_inst); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_pass();
        in_valid = 1'b1; in_inst = 32'h8C220004; in_pc = 32'h00400000;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sp_out_valid: got %b exp 1", out_valid); end
        checks++; if (opcode !== 6'h23) begin errors++; $display("FAIL sp_opcode: got %h exp 23", opcode); end
        checks++; if (rs !== 5'd1) begin errors++; $display("FAIL sp_rs: got %0d exp 1", rs); end
        checks++; if (rt !== 5'd2) begin errors++; $display("FAIL sp_rt: got %0d exp 2", rt); end
        checks++; if (imm !== 16'h0004) begin errors++; $display("FAIL sp_imm: got %h exp 0004", imm); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL sp_count: got %0d exp 1", count); end
        checks++; if (out_pc !== 32'h00400000) begin errors++; $display("FAIL sp_out_pc: got %h exp 00400000", out_pc); end
        out_ready = 1'b1;
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL sp_pop_count: got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sp_pop_valid: got %b exp 0", out_valid); end
        checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL sp_pop_zero: got %h/%h exp 0/0", out_inst, out_pc); end
        checks++; if ({opcode, rs, rt, imm} !== 32'h0 || target !== 26'h0) begin errors++; $display("FAIL sp_pop_fields: got %h exp 0", {opcode, rs, rt, imm}); end
        // out_ready held while empty must not underflow
        step();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL sp_underflow: got %0d exp 0", count); end
    endtask

    task automatic test_rtype();
        in_valid = 1'b1; in_inst = 32'h00851020; in_pc = 32'h00400010;
        step();
        in_valid = 1'b0;
        checks++; if (rs !== 5'd4) begin errors++; $display("FAIL rt_rs: got %0d exp 4", rs); end
        checks++; if (rt !== 5'd5) begin errors++; $display("FAIL rt_rt: got %0d exp 5", rt); end
        checks++; if (rd !== 5'd2) begin errors++; $display("FAIL rt_rd: got %0d exp 2", rd); end
        checks++; if (shamt !== 5'd0) begin errors++; $display("FAIL rt_shamt: got %0d exp 0", shamt); end
        checks++; if (funct !== 6'h20) begin errors++; $display("FAIL rt_funct: got %h exp 20", funct); end
        checks++; if (target !== 26'h0851020) begin errors++; $display("FAIL rt_target: got %h exp 0851020", target); end
        checks++; if (opcode !== 6'h00) begin errors++; $display("FAIL rt_opcode: got %h exp 00", opcode); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_fill_backpressure();
        logic [31:0] w [5];
        logic [31:0] p [5];
        w[0] = 32'hA0000001; w[1] = 32'hB0000002; w[2] = 32'hC0000003;
        w[3] = 32'hD0000004; w[4] = 32'hE0000005;
        for (int i = 0; i < 5; i++) p[i] = 32'h00001000 + 32'(i * 4);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_inst = w[i]; in_pc = p[i];
            if (i < 4) exp_q.push_back({w[i], p[i]});
            if (i == 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b exp 0", in_ready); end
            end
            step();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d exp 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b exp 0", in_ready); end
        head = exp_q.pop_front();
        checks++; if ({out_inst, out_pc} !== head) begin errors++; $display("FAIL fill_head: got %h exp %h", {out_inst, out_pc}, head); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_pop_count: got %0d exp 3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_pop_ready: got %b exp 1", in_ready); end
        exp_q.push_back({w[4], p[4]});
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_e_count: got %0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            head = exp_q.pop_front();
            checks++; if ({out_inst, out_pc} !== head) begin errors++; $display("FAIL fill_drain%0d: got %h exp %h", i, {out_inst, out_pc}, head); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_empty: got %0d exp 0", count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic [31:0] p;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            w = 32'h20080000 + 32'(i); p = 32'h00402000 + 32'(i * 4);
            in_valid = 1'b1; in_inst = w; in_pc = p;
            exp_q.push_back({w, p});
            step();
        end
        for (int i = 2; i < 10; i++) begin
            w = 32'h20080000 + 32'(i); p = 32'h00402000 + 32'(i * 4);
            in_valid = 1'b1; in_inst = w; in_pc = p; out_ready = 1'b1;
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d exp 2", i, count); end
            head = exp_q.pop_front();
            checks++; if ({out_inst, out_pc} !== head) begin errors++; $display("FAIL b2b_head%0d: got %h exp %h", i, {out_inst, out_pc}, head); end
            exp_q.push_back({w, p});
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_final_count: got %0d exp 2", count); end
        for (int i = 0; i < 2; i++) begin
            head = exp_q.pop_front();
            checks++; if ({out_inst, out_pc} !== head) begin errors++; $display("FAIL b2b_drain%0d: got %h exp %h", i, {out_inst, out_pc}, head); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = 32'h30000000 + 32'(i); in_pc = 32'h00403000 + 32'(i * 4);
            step();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fl_pre_count: got %0d exp 3", count); end
        in_valid = 1'b1; in_inst = 32'hFFFF0001; in_pc = 32'h00403100;
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fl_count: got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL fl_out_inst: got %h exp 0", out_inst); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_in_ready: got %b exp 1", in_ready); end
        in_valid = 1'b1; in_inst = 32'h08100004; in_pc = 32'h00403200;
        step();
        in_valid = 1'b0;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL fl_post_count: got %0d exp 1", count); end
        checks++; if ({out_inst, out_pc} !== {32'h08100004, 32'h00403200}) begin errors++; $display("FAIL fl_post_head: got %h/%h exp 08100004/00403200", out_inst, out_pc); end
        checks++; if (target !== 26'h0100004) begin errors++; $display("FAIL fl_post_target: got %h exp 0100004", target); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_drain_empty: got %b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_inst = 32'h40000000 + 32'(i); in_pc = 32'h00404000 + 32'(i * 4);
            step();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL ar_pre_count: got %0d exp 2", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready: got %b exp 1", in_ready); end
        checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL ar_outputs: got %h/%h exp 0/0", out_inst, out_pc); end
        #2;
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_inst = 32'h8C430008; in_pc = 32'h00405000;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_idle_valid: got %b exp 0", out_valid); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_push_valid: got %b exp 1", out_valid); end
        checks++; if ({out_inst, out_pc} !== {32'h8C430008, 32'h00405000}) begin errors++; $display("FAIL ar_push_head: got %h/%h exp 8C430008/00405000", out_inst, out_pc); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL ar_push_count: got %0d exp 1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_rtype();
        test_fill_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
